// File: rtl/nrisc_pc_stack.sv
// Program counter plus return-address stack for the NRISC core.
// One operation per clock; CALL saves {PC+1, flags}, RET restores them.
module nrisc_pc_stack #(
   parameter int unsigned     TAM      = 16,
   parameter int unsigned     DEPTH    = 8,
   parameter int unsigned     FLAGS    = 3,
   parameter logic [TAM-1:0]  RESET_PC = '0,
   localparam int unsigned    SPW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       pc_ctrl,
   input  logic [TAM-1:0]   target,
   input  logic [FLAGS-1:0] flags_in,
   input  logic             err_clr,
   output logic [TAM-1:0]   PC,
   output logic [FLAGS-1:0] flags_out,
   output logic             flags_restore,
   output logic [SPW-1:0]   sp,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned EW = TAM + FLAGS;

   typedef enum logic [2:0] {
      OpInc    = 3'b000,
      OpHold   = 3'b001,
      OpJump   = 3'b010,
      OpBranch = 3'b011,
      OpCall   = 3'b100,
      OpRet    = 3'b101
   } pc_op_e;

   pc_op_e           op;
   logic [TAM-1:0]   pc_q, pc_d, pc_inc;
   logic [SPW-1:0]   sp_q, sp_d;
   logic [FLAGS-1:0] flags_out_q, flags_out_d;
   logic             flags_restore_q, flags_restore_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             push_en;
   logic [AW-1:0]    wr_idx, rd_idx;
   logic [EW-1:0]    rd_entry;

   // Storage is intentionally not reset; sp alone defines what is valid.
   logic [EW-1:0]    stack_q [DEPTH];

   assign op       = pc_op_e'(pc_ctrl);
   assign pc_inc   = pc_q + TAM'(1);
   assign wr_idx   = AW'(sp_q);
   assign rd_idx   = AW'(sp_q - SPW'(1));
   assign rd_entry = stack_q[rd_idx];

   assign full  = (sp_q == SPW'(DEPTH));
   assign empty = (sp_q == '0);

   always_comb begin
      pc_d            = pc_q;
      sp_d            = sp_q;
      flags_out_d     = flags_out_q;
      flags_restore_d = 1'b0;
      overflow_d      = overflow_q & ~err_clr;
      underflow_d     = underflow_q & ~err_clr;
      push_en         = 1'b0;

      case (op)
         OpInc:    pc_d = pc_inc;
         OpJump:   pc_d = target;
         OpBranch: pc_d = pc_q + target;
         OpCall: begin
            if (full) begin
               overflow_d = 1'b1;
            end else begin
               push_en = 1'b1;
               sp_d    = sp_q + SPW'(1);
               pc_d    = target;
            end
         end
         OpRet: begin
            if (empty) begin
               underflow_d = 1'b1;
            end else begin
               pc_d            = rd_entry[EW-1:FLAGS];
               flags_out_d     = rd_entry[FLAGS-1:0];
               sp_d            = sp_q - SPW'(1);
               flags_restore_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q            <= RESET_PC;
         sp_q            <= '0;
         flags_out_q     <= '0;
         flags_restore_q <= 1'b0;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         sp_q            <= sp_d;
         flags_out_q     <= flags_out_d;
         flags_restore_q <= flags_restore_d;
         overflow_q      <= overflow_d;
         underflow_q     <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[wr_idx] <= {pc_inc, flags_in};
      end
   end

   assign PC            = pc_q;
   assign sp            = sp_q;
   assign flags_out     = flags_out_q;
   assign flags_restore = flags_restore_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

endmodule

// File: tb/tb_nrisc_pc_stack.sv
// Directed bench for nrisc_pc_stack: queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the way.
module tb_nrisc_pc_stack;

   localparam int unsigned TAM   = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned FLAGS = 3;
   localparam int unsigned SPW   = $clog2(DEPTH + 1);

   localparam logic [2:0] INC = 3'b000, HOLD = 3'b001, JUMP = 3'b010,
                          BRANCH = 3'b011, CALL = 3'b100, RET = 3'b101;

   logic             clk, rst;
   logic [2:0]       pc_ctrl;
   logic [TAM-1:0]   target;
   logic [FLAGS-1:0] flags_in;
   logic             err_clr;
   logic [TAM-1:0]   PC;
   logic [FLAGS-1:0] flags_out;
   logic             flags_restore;
   logic [SPW-1:0]   sp;
   logic             full, empty, overflow, underflow;

   nrisc_pc_stack #(
      .TAM      (TAM),
      .DEPTH    (DEPTH),
      .FLAGS    (FLAGS),
      .RESET_PC (16'h0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_ctrl       (pc_ctrl),
      .target        (target),
      .flags_in      (flags_in),
      .err_clr       (err_clr),
      .PC            (PC),
      .flags_out     (flags_out),
      .flags_restore (flags_restore),
      .sp            (sp),
      .full          (full),
      .empty         (empty),
      .overflow      (overflow),
      .underflow     (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: return stack as a queue of {addr, flags}.
   typedef struct {
      logic [TAM-1:0]   addr;
      logic [FLAGS-1:0] fl;
   } entry_t;

   entry_t           stk[$];
   logic [TAM-1:0]   m_pc;
   logic [FLAGS-1:0] m_flags;
   logic             m_restore, m_ov, m_un;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         stk.delete();
         m_pc      = 16'h0000;
         m_flags   = '0;
         m_restore = 1'b0;
         m_ov      = 1'b0;
         m_un      = 1'b0;
      end else begin
         m_restore = 1'b0;
         if (err_clr) begin
            m_ov = 1'b0;
            m_un = 1'b0;
         end
         case (pc_ctrl)
            INC:    m_pc = m_pc + 16'd1;
            JUMP:   m_pc = target;
            BRANCH: m_pc = m_pc + target;
            CALL: begin
               if (stk.size() == DEPTH) m_ov = 1'b1;
               else begin
                  entry_t e;
                  e.addr = m_pc + 16'd1;
                  e.fl   = flags_in;
                  stk.push_back(e);
                  m_pc = target;
               end
            end
            RET: begin
               if (stk.size() == 0) m_un = 1'b1;
               else begin
                  entry_t e;
                  e = stk.pop_back();
                  m_pc      = e.addr;
                  m_flags   = e.fl;
                  m_restore = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("pc", 32'(PC), 32'(m_pc));
         chk("sp", 32'(sp), 32'(stk.size()));
         chk("full", 32'(full), 32'(stk.size() == DEPTH));
         chk("empty", 32'(empty), 32'(stk.size() == 0));
         chk("flags_out", 32'(flags_out), 32'(m_flags));
         chk("flags_restore", 32'(flags_restore), 32'(m_restore));
         chk("overflow", 32'(overflow), 32'(m_ov));
         chk("underflow", 32'(underflow), 32'(m_un));
      end
   end

   // Called at a falling edge; applies inputs for the next rising edge and
   // returns at the following falling edge.
   task automatic step(input logic [2:0] c, input logic [15:0] t,
                       input logic [2:0] f, input logic clr);
      pc_ctrl  = c;
      target   = t;
      flags_in = f;
      err_clr  = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      pc_ctrl  = HOLD;
      target   = '0;
      flags_in = '0;
      err_clr  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc", 32'(PC), 32'h0);
      chk("rst_sp", 32'(sp), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_restore", 32'(flags_restore), 32'h0);
      rst    = 1'b1;
      cmp_en = 1'b1;

      step(INC, 16'h0, 3'b0, 1'b0); chk("inc1", 32'(PC), 32'h1);
      step(INC, 16'h0, 3'b0, 1'b0); chk("inc2", 32'(PC), 32'h2);
      step(INC, 16'h0, 3'b0, 1'b0); chk("inc3", 32'(PC), 32'h3);

      step(JUMP, 16'h0010, 3'b0, 1'b0);
      step(CALL, 16'h0200, 3'b101, 1'b0);
      chk("call_pc", 32'(PC), 32'h0200);
      chk("call_sp", 32'(sp), 32'h1);
      step(INC, 16'h0, 3'b0, 1'b0);
      chk("call_inc", 32'(PC), 32'h0201);
      step(RET, 16'h0, 3'b0, 1'b0);
      chk("ret_pc", 32'(PC), 32'h0011);
      chk("ret_flags", 32'(flags_out), 32'h5);
      chk("ret_pulse", 32'(flags_restore), 32'h1);
      step(HOLD, 16'h0, 3'b0, 1'b0);
      chk("pulse_end", 32'(flags_restore), 32'h0);

      step(JUMP, 16'h0005, 3'b0, 1'b0);
      step(BRANCH, 16'hFFFE, 3'b0, 1'b0);
      chk("branch_neg", 32'(PC), 32'h0003);
      step(JUMP, 16'hFFFF, 3'b0, 1'b0);
      step(INC, 16'h0, 3'b0, 1'b0);
      chk("inc_wrap", 32'(PC), 32'h0000);
      step(JUMP, 16'hFFFF, 3'b0, 1'b0);
      step(CALL, 16'h0100, 3'b011, 1'b0);
      step(RET, 16'h0, 3'b0, 1'b0);
      chk("call_wrap_ret", 32'(PC), 32'h0000);

      step(JUMP, 16'h0011, 3'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(CALL, 16'h1000 + 16'(i), 3'(i), 1'b0);
      chk("fill_sp", 32'(sp), 32'h8);
      chk("fill_full", 32'(full), 32'h1);
      step(CALL, 16'h3000, 3'b0, 1'b0);
      chk("ovf_pc", 32'(PC), 32'h1007);
      chk("ovf_set", 32'(overflow), 32'h1);
      step(HOLD, 16'h0, 3'b0, 1'b1);
      chk("ovf_clr", 32'(overflow), 32'h0);
      step(CALL, 16'h3000, 3'b0, 1'b1);
      chk("ovf_set_wins", 32'(overflow), 32'h1);
      step(HOLD, 16'h0, 3'b0, 1'b1);

      step(RET, 16'h0, 3'b0, 1'b0);
      chk("ret_first", 32'(PC), 32'h1007);
      for (int i = 0; i < 7; i++) step(RET, 16'h0, 3'b0, 1'b0);
      chk("ret_last", 32'(PC), 32'h0012);
      step(RET, 16'h0, 3'b0, 1'b0);
      chk("unf_set", 32'(underflow), 32'h1);
      chk("unf_pc", 32'(PC), 32'h0012);
      step(HOLD, 16'h0, 3'b0, 1'b1);

      for (int i = 0; i < 8; i++) step(CALL, 16'h2000 + 16'(i), 3'b110, 1'b0);
      step(RET, 16'h0, 3'b0, 1'b0);
      step(CALL, 16'h4000, 3'b001, 1'b0);
      chk("refill_sp", 32'(sp), 32'h8);
      chk("refill_ovf", 32'(overflow), 32'h0);
      chk("refill_pc", 32'(PC), 32'h4000);

      repeat (5) step(RET, 16'h0, 3'b0, 1'b0);
      chk("pre_rst_sp", 32'(sp), 32'h3);
      #3 rst = 1'b0;
      #1;
      chk("async_pc", 32'(PC), 32'h0);
      chk("async_sp", 32'(sp), 32'h0);
      chk("async_empty", 32'(empty), 32'h1);
      chk("async_full", 32'(full), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step(RET, 16'h0, 3'b0, 1'b0);
      chk("post_rst_unf", 32'(underflow), 32'h1);
      chk("post_rst_pc", 32'(PC), 32'h0);
      step(HOLD, 16'h0, 3'b0, 1'b0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nrisc_pc_stack.md
# nrisc_pc_stack

Program-counter and return-stack unit for the NRISC CPU. It replaces the inline PC register and the unimplemented stack path with one parametrised block. It owns the PC, a LIFO of return addresses with saved ULA flags, and the error status the core needs. The core drives one operation code per clock; the block updates the PC, pushes or pops the stack, and hands restored flags back to the flag register.

## Interface
Parameters:
- TAM, 16: PC, target and return-address width in bits.
- DEPTH, 8: stack entries (≥2). SPW = clog2(DEPTH+1).
- FLAGS, 3: saved flag width.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc_ctrl  in  3  operation: 000 INC, 001 HOLD, 010 JUMP, 011 BRANCH, 100 CALL, 101 RET; 110/111 are reserved and act as HOLD.
- target  in  TAM  JUMP/CALL absolute address; BRANCH signed two's-complement offset.
- flags_in  in  FLAGS  ULA flags saved by CALL.
- err_clr  in  1  clears the sticky error bits.
- PC  out  TAM  current program counter (registered).
- flags_out  out  FLAGS  flags popped by the last successful RET (registered).
- flags_restore  out  1  one-cycle pulse in the cycle after a successful RET.
- sp  out  SPW  number of occupied stack entries (registered).
- full  out  1  sp == DEPTH (decoded from the sp register).
- empty  out  1  sp == 0 (decoded from the sp register).
- overflow  out  1  sticky: a CALL was attempted while full.
- underflow  out  1  sticky: a RET was attempted while empty.

## Operation
- Stack storage is DEPTH entries of {TAM-bit return address, FLAGS-bit flags}. Storage is not reset and is never read at or above sp.
- INC: PC ← PC+1, modulo 2^TAM (0xFFFF wraps to 0x0000 at TAM=16).
- HOLD / reserved: no state change.
- JUMP: PC ← target.
- BRANCH: PC ← PC + target, TAM-bit two's-complement add; the carry is discarded and the result wraps.
- CALL, not full:
  - stack[sp] ← {PC+1 (wrapped), flags_in};
  - sp ← sp+1;
  - PC ← target.
- CALL while full: PC, sp and stack are unchanged; overflow ← 1.
- RET, not empty:
  - PC ← stack[sp-1].addr;
  - flags_out ← stack[sp-1].flags;
  - sp ← sp-1;
  - flags_restore ← 1 for exactly one cycle.
- RET while empty: PC, sp and flags_out are unchanged; underflow ← 1; flags_restore stays 0.
- flags_restore is 0 in every cycle not immediately following a successful RET.
- Back-to-back RETs produce back-to-back pulses.
- err_clr clears overflow and underflow on the next edge. If a new error occurs in the same cycle as err_clr, the set wins.
- Stack operations are strictly one per cycle: no simultaneous push and pop exists by encoding.

## Timing
- Every operation has 1-cycle latency: results are visible on outputs after the rising edge that samples pc_ctrl.
- full and empty follow sp combinationally, with no extra delay.
- No input-to-output combinational path exists apart from sp → full/empty.
- Reset is asserted (rst=0) asynchronously, independent of clk. While asserted:
  - PC = RESET_PC;
  - sp = 0, full = 0, empty = 1;
  - flags_out = 0, flags_restore = 0;
  - overflow = 0, underflow = 0.
- Reset in the middle of a call sequence discards all stack contents logically (sp = 0). The next RET therefore underflows.
- Release of rst is synchronised externally. The first operation is sampled on the first rising edge with rst=1.
- The full-to-not-full transition happens on the RET edge, so a CALL in the following cycle succeeds.

## Test plan
- Reset then INC ×3 (RESET_PC=0) -> PC 1, 2, 3; sp=0, empty=1; all errors 0.
- PC=0x0010, CALL target=0x0200, flags_in=3'b101, then INC, then RET -> PC 0x0200, then 0x0201, then 0x0011; sp 1→1→0; flags_out=3'b101 with flags_restore high exactly one cycle.
- From reset, CALL 9 times at DEPTH=8 -> sp=8 and full=1 after the 8th; on the 9th, PC unchanged and overflow=1. Then 8 RETs return the addresses in exact reverse order; a 9th RET sets underflow=1 with PC unchanged.
- PC=0x0005, BRANCH target=0xFFFE -> PC=0x0003. PC=0xFFFF, INC -> PC=0x0000. PC=0xFFFF, CALL -> pushed return address 0x0000.
- overflow=1, err_clr with HOLD -> overflow=0. While full, err_clr together with CALL -> overflow stays 1.
- After 3 CALLs, assert rst mid-cycle -> PC=RESET_PC and sp=0 immediately, without a clock edge. After release, RET -> underflow=1.
